// File: rtl/cap_c2sif_pkg.sv
// cap_c2sif_pkg: shared state enum and width helper for the c2sif capture stage
package cap_c2sif_pkg;
   typedef enum logic {HUNT, SHIFT} cap_state_e;
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction
endpackage

// File: rtl/cap_c2sif_fifo.sv
// cap_c2sif_fifo: synchronous FIFO with registered read port; a pop frees room for a same-cycle push when full
module cap_c2sif_fifo
   import cap_c2sif_pkg::*;
#(
   parameter int WORD_W = 8,
   parameter int DEPTH  = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      push,
   input  logic                      pop,
   input  logic                      flush,
   input  logic [WORD_W-1:0]         wdata,
   output logic [WORD_W-1:0]         rdata,
   output logic                      full,
   output logic                      empty,
   output logic [cnt_w(DEPTH)-1:0]   count
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = cnt_w(DEPTH);
   logic [WORD_W-1:0] mem [DEPTH];
   logic [AW-1:0] wptr, rptr;
   logic do_push, do_pop;
   assign full = count == CW'(DEPTH);
   assign empty = count == '0;
   assign do_pop = pop && !empty;
   assign do_push = push && (!full || do_pop);
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
         rdata <= '0;
      end else if (flush) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (do_push) wptr <= wptr + 1'b1;
         if (do_pop) begin
            rptr  <= rptr + 1'b1;
            rdata <= mem[rptr];
         end
         count <= count + CW'(do_push) - CW'(do_pop);
      end
   // when full, wptr equals rptr: the old head is read before being overwritten
   always_ff @(posedge clk)
      if (do_push && !flush) mem[wptr] <= wdata;
endmodule

// File: rtl/cap_c2sif.sv
// cap_c2sif: frames the DUT serial output into words and buffers them for a request/valid reader
module cap_c2sif
   import cap_c2sif_pkg::*;
#(
   parameter int id     = 1,
   parameter int WORD_W = 8,
   parameter int DEPTH  = 4,
   parameter int SYNC   = 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      en,
   input  logic                      flush,
   input  logic                      din,
   input  logic                      rd_req,
   output logic [WORD_W-1:0]         rd_data,
   output logic                      rd_valid,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      ovf,
   output logic                      busy
);
   localparam int BW = $clog2(WORD_W);
   localparam cap_state_e RST_ST = (SYNC != 0) ? HUNT : SHIFT;
   if (id < 0 || WORD_W < 2 || DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_param
      $error("cap_c2sif: illegal parameters");
   end
   cap_state_e state, nxt;
   logic [WORD_W-1:0] sreg, word;
   logic [BW-1:0] bitcnt;
   logic last, push, pop, full, empty;
   assign word = {sreg[WORD_W-2:0], din};
   assign last = bitcnt == BW'(WORD_W - 1);
   assign push = en && !flush && state == SHIFT && last;
   assign pop = rd_req && !flush;
   always_ff @(posedge clk or negedge rst)
      if (!rst) state <= RST_ST;
      else state <= nxt;
   always_comb begin
      nxt = state;
      if (flush) nxt = RST_ST;
      else if (en && state == HUNT && din) nxt = SHIFT;
      else if (push && SYNC != 0) nxt = HUNT;
   end
   always_comb busy = state == SHIFT;
   always_ff @(posedge clk or negedge rst)
      if (!rst) begin
         sreg     <= '0;
         bitcnt   <= '0;
         ovf      <= 1'b0;
         rd_valid <= 1'b0;
      end else if (flush) begin
         sreg     <= '0;
         bitcnt   <= '0;
         ovf      <= 1'b0;
         rd_valid <= 1'b0;
      end else begin
         if (en && state == SHIFT) begin
            sreg   <= word;
            bitcnt <= last ? '0 : bitcnt + 1'b1;
         end else if (en && state == HUNT && din) bitcnt <= '0;
         // full implies non-empty, so any request frees a slot this cycle
         if (push && full && !rd_req) ovf <= 1'b1;
         rd_valid <= rd_req && !empty;
      end
   cap_c2sif_fifo #(.WORD_W(WORD_W), .DEPTH(DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .pop   (pop),
      .flush (flush),
      .wdata (word),
      .rdata (rd_data),
      .full  (full),
      .empty (empty),
      .count (count)
   );
endmodule

// File: tb/tb_cap_c2sif.sv
// tb_cap_c2sif: scoreboard bench for cap_c2sif with default parameters
module tb_cap_c2sif;
   logic clk = 1'b0, rst = 1'b0, en = 1'b0, flush = 1'b0, din = 1'b0, rd_req = 1'b0;
   logic [7:0] rd_data;
   logic rd_valid, ovf, busy;
   logic [2:0] count;
   int n_chk = 0, n_err = 0;
   logic [7:0] q [$];
   cap_c2sif dut (
      .clk(clk), .rst(rst), .en(en), .flush(flush), .din(din), .rd_req(rd_req),
      .rd_data(rd_data), .rd_valid(rd_valid), .count(count), .ovf(ovf), .busy(busy)
   );
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask
   always @(negedge clk)
      if (rst && rd_valid) begin
         if (q.size() == 0) chk("rd_valid_spurious", {31'd0, rd_valid}, 32'd0);
         else chk("rd_data", {24'd0, rd_data}, {24'd0, q.pop_front()});
      end
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   task automatic send_bit(input logic b);
      en = 1'b1;
      din = b;
      tick();
   endtask
   task automatic send_frame(input logic [7:0] w, input bit exp, input int pause, input bit rd_last);
      send_bit(1'b1);
      for (int i = 7; i >= 0; i--) begin
         if (i == 0 && rd_last) rd_req = 1'b1;
         send_bit(w[i]);
         rd_req = 1'b0;
         if (pause > 0 && i == 4)
            for (int p = 0; p < pause; p++) begin
               en = 1'b0;
               tick();
               chk("busy_pause", {31'd0, busy}, 32'd1);
            end
      end
      en = 1'b0;
      din = 1'b0;
      if (exp) q.push_back(w);
   endtask
   task automatic pop_n(input int n);
      rd_req = 1'b1;
      repeat (n) tick();
      rd_req = 1'b0;
   endtask
   initial begin
      repeat (2) tick();
      chk("rst_rd_data", {24'd0, rd_data}, 32'd0);
      chk("rst_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("rst_count", {29'd0, count}, 32'd0);
      chk("rst_ovf", {31'd0, ovf}, 32'd0);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      rst = 1'b1;
      tick();
      send_bit(1'b0);
      send_bit(1'b0);
      chk("hunt_busy", {31'd0, busy}, 32'd0);
      send_frame(8'hA5, 1'b1, 0, 1'b0);
      chk("frame_count", {29'd0, count}, 32'd1);
      chk("frame_busy", {31'd0, busy}, 32'd0);
      pop_n(1);
      chk("pop_valid", {31'd0, rd_valid}, 32'd1);
      tick();
      chk("pop_valid_1cyc", {31'd0, rd_valid}, 32'd0);
      chk("pop_count", {29'd0, count}, 32'd0);
      send_frame(8'hA5, 1'b1, 3, 1'b0);
      chk("pause_count", {29'd0, count}, 32'd1);
      pop_n(1);
      tick();
      for (int k = 1; k <= 5; k++) begin
         send_frame(8'(k), k <= 4, 0, 1'b0);
         chk(k == 5 ? "ovf_set" : "ovf_clear", {31'd0, ovf}, {31'd0, k == 5});
      end
      chk("ovf_count", {29'd0, count}, 32'd4);
      pop_n(4);
      tick();
      chk("drain_count", {29'd0, count}, 32'd0);
      chk("drain_valid", {31'd0, rd_valid}, 32'd0);
      chk("ovf_sticky", {31'd0, ovf}, 32'd1);
      send_frame(8'hE1, 1'b0, 0, 1'b0);
      send_frame(8'hE2, 1'b0, 0, 1'b0);
      chk("pre_flush_count", {29'd0, count}, 32'd2);
      flush = 1'b1;
      rd_req = 1'b1;
      en = 1'b1;
      din = 1'b1;
      tick();
      flush = 1'b0;
      rd_req = 1'b0;
      en = 1'b0;
      din = 1'b0;
      chk("flush_count", {29'd0, count}, 32'd0);
      chk("flush_ovf", {31'd0, ovf}, 32'd0);
      chk("flush_valid", {31'd0, rd_valid}, 32'd0);
      chk("flush_busy", {31'd0, busy}, 32'd0);
      pop_n(1);
      chk("empty_rd_valid", {31'd0, rd_valid}, 32'd0);
      chk("empty_rd_data", {24'd0, rd_data}, 32'h04);
      foreach (q[i]) chk("q_empty_before_full", 32'd1, 32'd0);
      for (int k = 1; k <= 4; k++) send_frame(8'(8'h11 * k), 1'b1, 0, 1'b0);
      chk("full_count", {29'd0, count}, 32'd4);
      send_frame(8'h77, 1'b1, 0, 1'b1);
      chk("full_pp_ovf", {31'd0, ovf}, 32'd0);
      chk("full_pp_count", {29'd0, count}, 32'd4);
      tick();
      pop_n(4);
      tick();
      chk("full_drain_count", {29'd0, count}, 32'd0);
      send_frame(8'h99, 1'b0, 0, 1'b0);
      chk("pre_rst_count", {29'd0, count}, 32'd1);
      send_bit(1'b1);
      send_bit(1'b1);
      send_bit(1'b0);
      send_bit(1'b1);
      rst = 1'b0;
      #1;
      chk("async_rst_count", {29'd0, count}, 32'd0);
      chk("async_rst_busy", {31'd0, busy}, 32'd0);
      en = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      send_frame(8'h3C, 1'b1, 0, 1'b0);
      chk("rst_frame_count", {29'd0, count}, 32'd1);
      pop_n(1);
      tick();
      chk("final_count", {29'd0, count}, 32'd0);
      chk("q_left", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
